seq_divider: RTL and testbench

Sequential signed divider: the inverse companion of the team's Booth multiplier. It takes a 2N-bit signed dividend (a multiplier product) and an N-bit signed divisor. It returns a truncated quotient and remainder after a fixed number of cycles, using restoring division on magnitudes with a final sign-fix step. It sits beside the multiplier in the arithmetic lab datapath, so products can be divided back into their operands for round-trip checks.

---
 rtl/seq_divider.sv | 117 +++++++++++
 tb/tb_seq_divider.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - sequential signed restoring divider, 2N-bit dividend by N-bit divisor
module seq_divider #(
  parameter int N = 4
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  start,
  input  logic signed [2*N-1:0] dividend,
  input  logic signed [N-1:0]   divisor,
  output logic signed [2*N-1:0] quo,
  output logic signed [N-1:0]   rem,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int CW = $clog2(2*N) + 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(2*N-1);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t         state, state_nxt;
  logic [2*N-1:0] dvd_mag;
  logic [2*N-1:0] q_acc;
  logic [N-1:0]   dvs_mag;
  logic [N-1:0]   prem;
  logic [N-1:0]   rem_raw;
  logic [CW-1:0]  cnt;
  logic           qsign, rsign, ovf, dz;
  logic [N:0]     shifted, trial;
  logic           accept;

  assign accept = start && (state == IDLE || state == DONE);

  // prem < |divisor| <= 2^(N-1), so the shifted value fits N+1 bits and trial[N] is its sign
  always_comb begin
    shifted = {prem, dvd_mag[2*N-1]};
    trial   = shifted - {1'b0, dvs_mag};
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = (divisor == '0) ? FIX : RUN;
      RUN:        if (cnt == LAST_ITER) state_nxt = FIX;
      FIX:        state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      quo     <= '0;
      rem     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      dvd_mag <= '0;
      q_acc   <= '0;
      dvs_mag <= '0;
      prem    <= '0;
      rem_raw <= '0;
      cnt     <= '0;
      qsign   <= 1'b0;
      rsign   <= 1'b0;
      ovf     <= 1'b0;
      dz      <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            dvd_mag <= dividend[2*N-1] ? -dividend : dividend;
            dvs_mag <= divisor[N-1] ? -divisor : divisor;
            qsign   <= dividend[2*N-1] ^ divisor[N-1];
            rsign   <= dividend[2*N-1];
            ovf     <= (dividend == {1'b1, {(2*N-1){1'b0}}}) && (divisor == '1);
            dz      <= (divisor == '0);
            rem_raw <= dividend[N-1:0];
            prem    <= '0;
            q_acc   <= '0;
            cnt     <= '0;
            busy    <= 1'b1;
            done    <= 1'b0;
            err     <= 1'b0;
          end
        end
        RUN: begin
          prem    <= trial[N] ? shifted[N-1:0] : trial[N-1:0];
          q_acc   <= {q_acc[2*N-2:0], ~trial[N]};
          dvd_mag <= dvd_mag << 1;
          cnt     <= cnt + 1'b1;
        end
        FIX: begin
          if (dz) begin
            quo <= '0;
            rem <= rem_raw;
            err <= 1'b1;
          end else begin
            // -2^(2N-1) / -1 wraps back to -2^(2N-1) naturally; only the flag is special
            quo <= qsign ? -q_acc : q_acc;
            rem <= rsign ? -prem : prem;
            err <= ovf;
          end
          busy <= 1'b0;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - scoreboard bench for seq_divider with directed vectors and operand sweep
module tb_seq_divider;

  logic              clk = 1'b0;
  logic              rstN;
  logic              start;
  logic signed [7:0] dividend;
  logic signed [3:0] divisor;
  logic signed [7:0] quo;
  logic signed [3:0] rem;
  logic              busy, done, err;

  typedef struct {
    int dvd;
    int dvs;
    int q;
    int r;
    bit e;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   passed = 0;
  int   total  = 0;
  logic done_q = 1'b0;

  seq_divider #(.N(4)) dut (
    .clk(clk), .rstN(rstN), .start(start), .dividend(dividend), .divisor(divisor),
    .quo(quo), .rem(rem), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act == req) passed++;
    else $display("FAIL %s: got %0d, required %0d", name, act, req);
  endtask

  always @(negedge clk) begin
    if (rstN && done && !done_q) begin
      if (sb.size() == 0) begin
        total++;
        $display("FAIL unexpected_done: got done with no pending operation, required none");
      end else begin
        cur = sb.pop_front();
        check($sformatf("quo %0d/%0d", cur.dvd, cur.dvs), int'(quo), cur.q);
        check($sformatf("rem %0d/%0d", cur.dvd, cur.dvs), int'(rem), cur.r);
        check($sformatf("err %0d/%0d", cur.dvd, cur.dvs), int'(err), int'(cur.e));
        check("busy_at_done", int'(busy), 0);
        if (!cur.e) check("identity", int'(quo) * cur.dvs + int'(rem), cur.dvd);
      end
    end
    done_q = done;
  end

  // Called at a negedge; returns at the negedge where done is first seen, so
  // the next call issues its start on the first edge with done=1.
  task automatic do_op(input int dvd, input int dvs, input int q, input int r,
                       input bit e, input int lat_req);
    int lat;
    dividend = 8'(dvd);
    divisor  = 4'(dvs);
    start    = 1'b1;
    sb.push_back('{dvd, dvs, q, r, e});
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", int'(busy), 1);
    lat = 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check($sformatf("latency %0d/%0d", dvd, dvs), lat, lat_req);
  endtask

  initial begin
    int lat;
    rstN = 1'b0;
    start = 1'b0;
    dividend = '0;
    divisor = '0;
    repeat (2) @(negedge clk);
    check("reset_quo", int'(quo), 0);
    check("reset_rem", int'(rem), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_err", int'(err), 0);
    rstN = 1'b1;
    @(negedge clk);

    do_op(35, -5, -7, 0, 0, 9);
    do_op(-42, 4, -10, -2, 0, 9);
    do_op(42, -4, -10, 2, 0, 9);
    do_op(-42, -6, 7, 0, 0, 9);
    do_op(7, 0, 0, 7, 1, 1);
    do_op(-128, -1, -128, 0, 1, 9);

    // start re-pulsed mid-operation must be ignored
    dividend = -8'sd128;
    divisor  = 4'sd7;
    start    = 1'b1;
    sb.push_back('{-128, 7, -18, -2, 1'b0});
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!done && lat < 40) begin
      if (lat == 2) begin
        dividend = 8'sd10;
        divisor  = 4'sd2;
        start    = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    check("latency_repulse", lat, 9);

    // asynchronous reset in the middle of RUN
    dividend = 8'sd35;
    divisor  = -4'sd5;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("quo_hold_run", int'(quo), -18);
    #1 rstN = 1'b0;
    #1;
    check("async_rst_quo", int'(quo), 0);
    check("async_rst_rem", int'(rem), 0);
    check("async_rst_done", int'(done), 0);
    check("async_rst_busy", int'(busy), 0);
    #1 rstN = 1'b1;
    @(negedge clk);
    check("idle_after_rst_done", int'(done), 0);
    do_op(-24, 3, -8, 0, 0, 9);

    for (int a = -128; a < 128; a++) begin
      for (int b = -8; b < 8; b++) begin
        if (b != 0 && !(a == -128 && b == -1)) do_op(a, b, a / b, a % b, 0, 9);
      end
    end

    @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
